instr_queue: RTL and testbench

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue.sv | 105 ++++++++++
 tb/tb_instr_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
`default_nettype none

`ifndef WORD
`define WORD [31:0]
`endif
`ifndef INSTR_LEN
`define INSTR_LEN [31:0]
`endif

// ============================================================================
//  Module      : instr_queue
//  Description : Fetch-to-decode instruction queue. Circular buffer of
//                {pc, instr} entries with valid/ready handshakes on both
//                sides, a synchronous flush for taken branches and no
//                write-to-read bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_queue #(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic `WORD                  in_pc,
  input  logic `INSTR_LEN             in_instr,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic `WORD                  out_pc,
  output logic `INSTR_LEN             out_instr,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        full,
  output logic                        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Entry storage, kept as two parallel arrays so the fields stay readable
  logic `WORD      pc_mem    [DEPTH];
  logic `INSTR_LEN instr_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] occ;

  logic enq;
  logic deq;

  // Status flags depend only on occupancy, so in_ready never looks at
  // out_ready and no combinational path crosses the queue.
  assign full      = (occ == CNT_W'(DEPTH));
  assign empty     = (occ == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = occ;

  assign enq = in_valid && !full;
  assign deq = out_ready && !empty;

  // Head entry is presented from storage only; a fresh write shows up a
  // cycle later. Outputs read as zero while nothing is queued.
  assign out_pc    = empty ? '0 : pc_mem[head];
  assign out_instr = empty ? '0 : instr_mem[head];

  // Pointer update: reset beats flush, flush discards any same-cycle request
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
    end
  end

  // Occupancy counter: a simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ <= '0;
    end else begin
      case ({enq, deq})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage write at tail; contents are left untouched by reset and flush,
  // only the pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (!reset && !flush && enq) begin
      pc_mem[tail]    <= in_pc;
      instr_mem[tail] <= in_instr;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_queue.sv
`default_nettype none

// ============================================================================
//  Module      : tb_instr_queue
//  Description : Self-checking bench for instr_queue (DEPTH=4) using a
//                queue scoreboard of expected {pc, instr} entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [31:0]   in_pc, in_instr;
  logic          in_ready, out_valid, full, empty;
  logic [31:0]   out_pc, out_instr;
  logic [CW-1:0] count;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] sb [$];

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc * 32'd3) ^ 32'h1234_5678;
  endfunction

  // Apply one cycle of stimulus and advance the scoreboard model with it
  task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                      input logic fl, input logic rst);
    logic e, d;
    @(negedge clk);
    in_valid = v; in_pc = pc; in_instr = instr_of(pc);
    out_ready = rdy; flush = fl; reset = rst;
    @(posedge clk);
    if (rst || fl) begin
      sb.delete();
    end else begin
      e = v && (sb.size() < DEPTH);
      d = rdy && (sb.size() > 0);
      if (d) void'(sb.pop_front());
      if (e) sb.push_back({pc, instr_of(pc)});
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 32'h99, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h98, 1'b0, 1'b0, 1'b1);
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++; if ({empty, full, in_ready, out_valid} !== 4'b1010) begin miscompares++; $display("FAIL reset_flags: got %b want 1010", {empty, full, in_ready, out_valid}); end
    vectors++; if ({out_pc, out_instr} !== 64'd0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", {out_pc, out_instr}); end
    // Dequeue request while empty must not move anything
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    vectors++; if (count !== '0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL empty_pop: got count %0d valid %b want 0 0", count, out_valid); end
  endtask

  task automatic test_fill();
    logic [CW-1:0] exp_c;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'(4 * i), 1'b0, 1'b0, 1'b0);
      exp_c = CW'(sb.size());
      vectors++; if (count !== exp_c) begin miscompares++; $display("FAIL fill_count: got %0d want %0d", count, exp_c); end
    end
    vectors++; if ({full, in_ready, empty} !== 3'b100) begin miscompares++; $display("FAIL fill_flags: got %b want 100", {full, in_ready, empty}); end
    step(1'b1, 32'd16, 1'b0, 1'b0, 1'b0);
    vectors++; if (count !== CW'(4) || out_pc !== 32'd0) begin miscompares++; $display("FAIL fill_drop: got count %0d head %h want 4 0", count, out_pc); end
  endtask

  task automatic test_drain();
    logic [31:0] exp_pc;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(4 * i);
      vectors++; if (out_pc !== exp_pc || out_pc !== sb[0][63:32] || out_instr !== sb[0][31:0])
        begin miscompares++; $display("FAIL drain_order: got %h/%h want %h/%h", out_pc, out_instr, exp_pc, sb[0][31:0]); end
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    vectors++; if (empty !== 1'b1 || out_pc !== 32'd0) begin miscompares++; $display("FAIL drain_empty: got empty %b pc %h want 1 0", empty, out_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] prev_pc;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      prev_pc = 32'h100 + 32'(4 * i);
      vectors++; if (count !== CW'(1) || out_pc !== prev_pc)
        begin miscompares++; $display("FAIL stream: got count %0d pc %h want 1 %h", count, out_pc, prev_pc); end
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL stream_end: got empty %b want 1", empty); end
  endtask

  task automatic test_wrap();
    int writes = 0;
    int reads  = 0;
    int guard  = 0;
    logic v, r;
    while ((writes < 10 || sb.size() > 0) && guard < 200) begin
      guard++;
      v = (writes < 10) && (sb.size() < 3);
      r = (sb.size() > 0) && ($urandom_range(0, 2) != 0 || writes >= 10);
      if (r) begin
        vectors++; if (out_pc !== 32'h200 + 32'(4 * reads) || out_instr !== sb[0][31:0])
          begin miscompares++; $display("FAIL wrap_order: got %h want %h", out_pc, 32'h200 + 32'(4 * reads)); end
        reads++;
      end
      step(v, 32'h200 + 32'(4 * writes), r, 1'b0, 1'b0);
      if (v) writes++;
      vectors++; if (count !== CW'(writes - reads))
        begin miscompares++; $display("FAIL wrap_count: got %0d want %0d", count, writes - reads); end
    end
    vectors++; if (guard >= 200 || empty !== 1'b1) begin miscompares++; $display("FAIL wrap_done: got empty %b after %0d cycles want 1", empty, guard); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    vectors++; if (count !== CW'(3)) begin miscompares++; $display("FAIL flush_pre: got %0d want 3", count); end
    step(1'b1, 32'h3F0, 1'b1, 1'b1, 1'b0);
    vectors++; if (count !== '0 || empty !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL flush: got count %0d empty %b want 0 1", count, empty); end
    step(1'b1, 32'h3A0, 1'b0, 1'b0, 1'b0);
    vectors++; if (out_pc !== 32'h3A0 || count !== CW'(1)) begin miscompares++; $display("FAIL flush_after: got %h/%0d want 3a0/1", out_pc, count); end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    step(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
    vectors++; if (count !== CW'(2)) begin miscompares++; $display("FAIL rmid_pre: got %0d want 2", count); end
    step(1'b1, 32'h508, 1'b1, 1'b0, 1'b1);
    vectors++; if (count !== '0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_reset: got count %0d valid %b want 0 0", count, out_valid); end
    // Present pc 0x40; it must not be visible before the capturing edge
    @(negedge clk);
    in_valid = 1'b1; in_pc = 32'h40; in_instr = instr_of(32'h40); out_ready = 1'b0; reset = 1'b0; flush = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || out_pc !== 32'd0) begin miscompares++; $display("FAIL no_bypass: got valid %b pc %h want 0 0", out_valid, out_pc); end
    @(posedge clk);
    sb.push_back({32'h40, instr_of(32'h40)});
    #1;
    vectors++; if (out_pc !== 32'h40 || out_instr !== sb[0][31:0]) begin miscompares++; $display("FAIL rmid_enq: got %h/%h want 40/%h", out_pc, out_instr, sb[0][31:0]); end
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
